// File: rtl/accumulator_pkg.sv
// Shared FSM state, default widths and the clamp-constant helper for the partial-sum accumulator.
// Pure declarations: no latency, no flow control.
package accumulator_pkg;

  localparam int ACC_IN_W    = 32;
  localparam int ACC_OUT_W   = 32;
  localparam int ACC_MAX_K   = 256;
  localparam int ACC_LIMIT_W = 64;  // widest accumulator sat_limit can describe

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // Clamp value for a w-bit accumulator, right-aligned; callers size-cast to their width.
  function automatic logic [ACC_LIMIT_W-1:0] sat_limit(input logic is_signed, input logic neg,
                                                       input int w);
    logic [ACC_LIMIT_W-1:0] r;
    if (!is_signed)
      r = (64'd1 << w) - 64'd1;
    else if (neg)
      r = 64'd1 << (w - 1);
    else
      r = (64'd1 << (w - 1)) - 64'd1;
    return r;
  endfunction

endpackage

// File: rtl/acc_add_sat.sv
// Combinational extend-and-add with overflow detect; clamps on overflow when ACC_SATURATE_EN is defined.
// Zero latency, no flow control.
module acc_add_sat
  import accumulator_pkg::*;
#(
  parameter int IN_W  = ACC_IN_W,
  parameter int ACC_W = ACC_OUT_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  data,
  input  logic             is_signed,
  input  logic             first,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] a;
  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   wide;
  logic             sgn_ovf;

  // The first beat of an element starts from zero rather than the stale accumulator.
  assign a    = first ? '0 : acc;
  assign ext  = is_signed ? ACC_W'(signed'(data)) : ACC_W'(data);
  assign wide = {1'b0, a} + {1'b0, ext};

  assign sgn_ovf = (a[ACC_W-1] == ext[ACC_W-1]) && (wide[ACC_W-1] != a[ACC_W-1]);
  assign ovf     = is_signed ? sgn_ovf : wide[ACC_W];

`ifdef ACC_SATURATE_EN
  // On signed overflow both operands share a sign, so the addend's sign picks max or min.
  assign sum = ovf ? ACC_W'(sat_limit(is_signed, ext[ACC_W-1], ACC_W)) : wide[ACC_W-1:0];
`else
  assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/partial_sum_accumulator.sv
// Accumulates k beats of tree-adder partial sums into one element (optional clamp: ACC_SATURATE_EN).
// Result valid the cycle after the last beat; in HOLD inReady follows outReady, giving back-to-back elements.
module partial_sum_accumulator
  import accumulator_pkg::*;
#(
  parameter int IN_W  = ACC_IN_W,
  parameter int ACC_W = ACC_OUT_W,
  parameter int MAX_K = ACC_MAX_K
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(MAX_K):0]     kLength,
  input  logic                       signedAddition,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [IN_W-1:0]            inData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [ACC_W-1:0]           outData,
  output logic                       overflow,
  output logic                       busy
);

  localparam int CW = $clog2(MAX_K) + 1;

  acc_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    k_q, k_d;
  logic [CW-1:0]    k_eff;
  logic             sgn_q, sgn_d;
  logic             ovf_q, ovf_d;
  logic             rdy_en_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic             accept;
  logic             first;
  logic             last;

  always_comb begin
    k_eff = kLength;
    if (kLength == '0)
      k_eff = CW'(1);
    else if (kLength > CW'(MAX_K))
      k_eff = CW'(MAX_K);
  end

  // rdy_en_q keeps rst off the combinational path to inReady.
  assign inReady = rdy_en_q && ((state_q != HOLD) || outReady);
  assign accept  = inValid && inReady;
  assign first   = accept && (state_q != ACCUM);
  assign last    = first ? (k_eff == CW'(1)) : ((cnt_q + CW'(1)) == k_q);

  acc_add_sat #(
    .IN_W (IN_W),
    .ACC_W(ACC_W)
  ) u_add (
    .acc      (acc_q),
    .data     (inData),
    .is_signed(first ? signedAddition : sgn_q),
    .first    (first),
    .sum      (sum),
    .ovf      (add_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    sgn_d   = sgn_q;
    ovf_d   = ovf_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE, HOLD: begin
        if (first) begin
          k_d     = k_eff;
          sgn_d   = signedAddition;
          cnt_d   = CW'(1);
          acc_d   = sum;
          ovf_d   = add_ovf;
          state_d = last ? HOLD : ACCUM;
        end else if ((state_q == HOLD) && outReady) begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + CW'(1);
          acc_d = sum;
          ovf_d = ovf_q | add_ovf;
`ifdef ACC_SATURATE_EN
          // Once clamped, the element stays pinned at the limit.
          if (ovf_q)
            acc_d = acc_q;
`endif
          if (last)
            state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      k_q      <= '0;
      sgn_q    <= 1'b0;
      ovf_q    <= 1'b0;
      acc_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      sgn_q    <= sgn_d;
      ovf_q    <= ovf_d;
      acc_q    <= acc_d;
      rdy_en_q <= 1'b1;
    end
  end

  assign outValid = (state_q == HOLD);
  assign busy     = (state_q == ACCUM);
  assign outData  = acc_q;
  assign overflow = ovf_q;

endmodule

// File: doc/partial_sum_accumulator.md
# partial_sum_accumulator

Downstream stage of the binary tree adder. It consumes one 32-bit reduced partial sum per beat over a valid/ready handshake and accumulates `kLength` consecutive beats into one output element. It presents the finished sum on a valid/ready output port. It lets a fixed-width dot-product tree cover reduction depths larger than its input count, with back-to-back results at full throughput.

## Interface
Parameters:
- `IN_W`, 32: width of `inData` (tree adder 32-bit output).
- `ACC_W`, 32: accumulator and `outData` width; must be ≥ `IN_W`.
- `MAX_K`, 256: largest supported `kLength`; counter width is `$clog2(MAX_K)+1`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `kLength`  in  `$clog2(MAX_K)+1`  beats per output element; sampled on the first beat of an element.
- `signedAddition`  in  1  1 = sign-extend inputs and use signed arithmetic; 0 = zero-extend; sampled on the first beat.
- `inValid`  in  1  upstream beat valid.
- `inReady`  out  1  block can accept a beat.
- `inData`  in  `IN_W`  partial sum from the tree adder.
- `outValid`  out  1  `outData` holds a finished element.
- `outReady`  in  1  downstream accepts the element.
- `outData`  out  `ACC_W`  accumulated result.
- `overflow`  out  1  the current result overflowed `ACC_W` at some beat (wrapped or clamped); valid with `outValid`.
- `busy`  out  1  an element is in progress (state ACCUM).

## Operation
- FSM states:
  - IDLE: no element in progress, no result held.
  - ACCUM: element in progress, `cnt` beats received.
  - HOLD: result presented.
- Beat accepted when `inValid && inReady`.
- `inReady` = 1 in IDLE and ACCUM. In HOLD, `inReady` = `outReady`, so a new element may start in the same cycle the result drains.
- First beat of an element (IDLE, or HOLD with the drain):
  - latch `k = max(kLength,1)` and the sign mode;
  - `acc = ext(inData)`; `cnt = 1`; clear the overflow flag.
  - Go to ACCUM, or to HOLD directly if `k == 1`.
- Later beats in ACCUM: `acc = acc + ext(inData)`, `cnt++`. When `cnt` reaches `k`, go to HOLD. The final sum is written to `outData` and `outValid` is set.
- HOLD:
  - `outData`, `outValid` and `overflow` stay stable until `outReady`.
  - On `outReady` with no new beat, go to IDLE and deassert `outValid`.
- No input beat in ACCUM: state and accumulator hold (bubbles allowed).
- Changes to `kLength` or `signedAddition` mid-element are ignored until the next first beat.
- `kLength > MAX_K`: clamp to `MAX_K`.
- Arithmetic:
  - `ext()` extends `IN_W` to `ACC_W` per the latched sign mode.
  - Overflow is detected on the `ACC_W+1`-bit sum: signed uses operand/result sign mismatch, unsigned uses carry-out.
  - Handling of an overflow depends on the Configuration macro.
- Reset mid-operation discards the element; no partial result is emitted.

## Timing
- Reset values: `inReady`=0 while `rst` is asserted, 1 in the first cycle after release. `outValid`=0, `outData`=0, `overflow`=0, `busy`=0, state IDLE, `cnt`=0, `acc`=0.
- Latency: the last accepted beat at edge N makes `outValid`=1 after edge N, observable in cycle N+1.
- Throughput: one element per `k` cycles with continuous `inValid` and `outReady`=1; no bubble between elements.
- `outValid` never deasserts without a handshake. `outData` never changes while `outValid && !outReady`.
- The path from `outReady` to `inReady` is combinational; this is the only input-to-output combinational path.

## Configuration
- `ACC_SATURATE_EN`:
  - Defined: on overflow, `acc` clamps to the `ACC_W` limit (signed max/min per operand sign, unsigned all-ones) and stays saturated for the rest of the element. `overflow` is set.
  - Undefined: `acc` wraps modulo 2^`ACC_W` and `overflow` is still set. No clamp logic is built.

## Structure
- Shared package `accumulator_pkg`:
  - FSM state enum `acc_state_e` {IDLE, ACCUM, HOLD};
  - function `sat_limit(signed, neg)` returning the clamp constant;
  - default width constants.
- One sub-module, `acc_add_sat`: a combinational add with extend, overflow detect and optional clamp (`ACC_SATURATE_EN` guarded inside). The top holds the FSM, counter and registers.

## Test plan
- `kLength`=4, unsigned, inputs 1,2,3,4 back-to-back, `outReady`=1 → `outData`=10 one cycle after the 4th beat, `overflow`=0.
- Signed, `kLength`=3, inputs -5,7,-10 → `outData`=0xFFFFFFF8 (-8). `kLength`=1 with input 9 → result 9 after one cycle, state goes straight to HOLD.
- `outReady`=0 for 5 cycles after `outValid` → `outData` stable, `inReady`=0. Then `outReady`=1 together with `inValid` → result drains and a new element starts in the same cycle.
- Signed, `ACC_W`=32, inputs 0x7FFFFFFF,1:
  - with `ACC_SATURATE_EN`: `outData`=0x7FFFFFFF, `overflow`=1;
  - without it: `outData`=0x80000000, `overflow`=1.
- Assert `rst` after 2 of 4 beats → all outputs 0 asynchronously. A fresh element 1,1,1,1 then yields 4.
- `kLength`=0 → behaves as 1. Change `kLength` from 4 to 2 mid-element → the element still takes 4 beats.
